// File: rtl/dmem_if.sv
// Data-memory port bundle between the CPU MEM stage (master) and the memory responder (slave).
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: one load/store in flight, response pulse LATENCY cycles after accept.
// Optional byte-lane stores are enabled by defining DMEM_BYTE_STROBE_EN.
module dmem_responder #(
  parameter int BIT_WIDTH   = 32,
  parameter int ENTRY_COUNT = 32,
  parameter int LATENCY     = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);
  localparam int         IDX_W    = $clog2(ENTRY_COUNT);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]           state, state_nxt;
  logic [3:0]           counter;
  logic                 lat_we;
  logic [31:0]          lat_addr, lat_wdata;
  logic [3:0]           lat_be;
  logic [BIT_WIDTH-1:0] mem [ENTRY_COUNT];

  logic                 accept, commit, addr_err;
  logic                 c_we;
  logic [31:0]          c_addr, c_wdata;
  logic [3:0]           c_be;
  logic [IDX_W-1:0]     idx;
  logic [BIT_WIDTH-1:0] wr_word;

  assign bus.req_ready = (state != S_WAIT);
  assign accept        = bus.req_valid & bus.req_ready;

  // With LATENCY==1 the commit edge is the accept edge, so the live request is committed directly.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    c_we    = lat_we;
    c_addr  = lat_addr;
    c_wdata = lat_wdata;
    c_be    = lat_be;
    if (state != S_WAIT) begin
      c_we    = bus.req_we;
      c_addr  = bus.req_addr;
      c_wdata = bus.req_wdata;
      c_be    = bus.req_be;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_RESP: begin
        if (accept) state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
        else        state_nxt = S_IDLE;
      end
      S_WAIT:  if (counter == 4'd1) state_nxt = S_RESP;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign commit   = (state_nxt == S_RESP);
  assign idx      = c_addr[IDX_W+1:2];
  assign addr_err = (c_addr[1:0] != 2'b00) || (c_addr >= 32'(4 * ENTRY_COUNT));

`ifdef DMEM_BYTE_STROBE_EN
  always_comb begin
    wr_word = mem[idx];
    for (int b = 0; b < 4; b++) begin
      if (c_be[b]) wr_word[8*b +: 8] = c_wdata[8*b +: 8];
    end
  end
`else
  logic unused_be;
  assign unused_be = ^c_be;
  assign wr_word   = c_wdata;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      counter   <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        counter   <= CNT_INIT;
        lat_we    <= bus.req_we;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
        lat_be    <= bus.req_be;
      end else if (state == S_WAIT) begin
        counter <= counter - 4'd1;
      end
    end
  end

  // NOTE: storage is cleared by reset, so the array is built from flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRY_COUNT; i++) mem[i] <= '0;
    end else if (commit && c_we && !addr_err) begin
      mem[idx] <= wr_word;
    end
  end

  // Response registers are loaded on the edge entering RESP and cleared on leaving it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else if (commit) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_err   <= addr_err;
      bus.rsp_rdata <= (!c_we && !addr_err) ? mem[idx] : '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver queues expected responses, a negedge monitor pops and compares.
module tb_dmem_responder;
  localparam int LAT = 2;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];
  exp_t mon_e;

  dmem_if bus();

  dmem_responder #(
    .BIT_WIDTH  (32),
    .ENTRY_COUNT(32),
    .LATENCY    (LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every response pulse must match the oldest queued expectation, including its cycle.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (bus.rsp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check({mon_e.name, "_rdata"}, bus.rsp_rdata, mon_e.rdata);
          check({mon_e.name, "_err"}, 32'(bus.rsp_err), 32'(mon_e.err));
          check({mon_e.name, "_cycle"}, cyc, mon_e.cyc);
        end
      end else begin
        check("idle_rdata_zero", bus.rsp_rdata, 32'd0);
        check("idle_err_zero", 32'(bus.rsp_err), 32'd0);
      end
    end
  end

  task automatic send(input string name, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input logic [31:0] exp_rdata, input logic exp_err,
                      input bit track, output int waited);
    exp_t e;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    waited = 0;
    while (bus.req_ready !== 1'b1 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    check({name, "_accept"}, 32'(bus.req_ready), 32'd1);
    if (track) begin
      e.name  = name;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.cyc   = cyc + LAT;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic ld(input string name, input logic [31:0] addr,
                    input logic [31:0] exp_rdata, input logic exp_err);
    int w;
    send(name, 1'b0, addr, 32'h0, 4'hF, exp_rdata, exp_err, 1'b1, w);
  endtask

  task automatic st(input string name, input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] be, input logic exp_err);
    int w;
    send(name, 1'b1, addr, data, be, 32'h0, exp_err, 1'b1, w);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({name, "_drained"}, sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    logic [31:0] exp_partial, exp_none;
`ifdef DMEM_BYTE_STROBE_EN
    exp_partial = 32'hAA22CC44;
    exp_none    = 32'hAA22CC44;
`else
    exp_partial = 32'h11223344;
    exp_none    = 32'h99999999;
`endif
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;

    repeat (3) @(negedge clk);
    check("reset_ready", 32'(bus.req_ready), 32'd1);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    rst = 1'b1;

    ld("load0_after_reset", 32'h0, 32'h0, 1'b0);
    st("store_deadbeef", 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    ld("load_deadbeef", 32'h10, 32'hDEADBEEF, 1'b0);
    drain("basic");

    st("b2b_store", 32'h10, 32'hCAFEF00D, 4'hF, 1'b0);
    send("b2b_load", 1'b0, 32'h10, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, 1'b1, w);
    check("b2b_wait_cycles", w, LAT - 1);
    drain("b2b");

    st("err_misaligned_store", 32'h12, 32'h55555555, 4'hF, 1'b1);
    ld("word4_unchanged", 32'h10, 32'hCAFEF00D, 1'b0);
    ld("err_range_load", 32'h80, 32'h0, 1'b1);
    st("last_word_store", 32'h7C, 32'h0BADCAFE, 4'hF, 1'b0);
    ld("last_word_load", 32'h7C, 32'h0BADCAFE, 1'b0);
    drain("err");

    send("rst_store", 1'b1, 32'h8, 32'h12345678, 4'hF, 32'h0, 1'b0, 1'b0, w);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_rst_ready", 32'(bus.req_ready), 32'd1);
    check("async_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    ld("dropped_store_load", 32'h8, 32'h0, 1'b0);
    ld("cleared_word4", 32'h10, 32'h0, 1'b0);
    ld("cleared_last_word", 32'h7C, 32'h0, 1'b0);
    drain("reset");

    st("be_init", 32'h4, 32'hAABBCCDD, 4'hF, 1'b0);
    st("be_partial", 32'h4, 32'h11223344, 4'b0101, 1'b0);
    ld("be_partial_load", 32'h4, exp_partial, 1'b0);
    st("be_none", 32'h4, 32'h99999999, 4'b0000, 1'b0);
    ld("be_none_load", 32'h4, exp_none, 1'b0);
    drain("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
